alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle integer ALU and the successor to the single-cycle datapath ALU. It supports add, sub, and, or, plus iterative multiply, unsigned divide and unsigned remainder. Operands enter through a valid/ready handshake, and the registered result and NZCV flags leave through a second valid/ready handshake. It sits in the execute stage of the multi-cycle core and stalls the core while busy.

Parameters:
WIDTH, 32, operand/result width in bits; legal values are 8 to 64.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, do not override.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operands and op are valid
in_ready  output  1  block can accept an op
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ALUControl  input  3  op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UDIV, 110 UREM, 111 reserved
out_valid  output  1  Result/ALUFlags are valid
out_ready  input  1  consumer takes the result
Result  output  WIDTH  registered result
ALUFlags  output  4  registered {N,Z,C,V}

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-operation):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, Result=0, ALUFlags=0, counter=0.
  - Any in-flight op is discarded.
- Accept: an op is accepted on the rising edge where in_valid&&in_ready. in_ready=1 only in IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of op 000-011 or 111: compute combinationally, register Result/flags, go to DONE. Latency 1 cycle (out_valid high the cycle after accept).
  - IDLE, accept of 100/101/110: latch a and b, clear the accumulator, counter=0, go to BUSY.
  - BUSY: perform one iteration per cycle, counter++. After WIDTH iterations, register Result/flags and go to DONE. Latency WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1. Result and ALUFlags are held stable until out_valid&&out_ready, then go to IDLE. in_ready rises the cycle after the handshake; there is no accept in the same cycle.
- Arithmetic:
  - ADD/SUB: sum = a + (SUB ? ~b : b) + SUB, computed WIDTH+1 bits wide.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. Result = low WIDTH bits of a*b.
  - UDIV/UREM: restoring division, one quotient bit per cycle, MSB first.
  - UDIV returns the quotient; UREM returns the remainder.
  - Divide by zero (b==0): UDIV Result = all ones; UREM Result = a. Latency is unchanged.
  - 111: Result=0.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result==0).
  - ADD/SUB: C = sum[WIDTH]; V = ~(a[MSB]^b[MSB]^SUB) & (a[MSB]^sum[MSB-1 equivalent MSB]), i.e. signed overflow.
  - MUL/UDIV/UREM: C=0. V=1 only for divide by zero, else 0.
  - AND/ORR/111: C=0, V=0.
- Input changes: a, b and ALUControl are ignored outside the accept cycle, so changing inputs during BUSY/DONE has no effect.
- out_ready asserted in IDLE/BUSY is ignored.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept; Result=0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB a=5 b=5 -> Result=0, flags N=0 Z=1 C=1 V=0; the next accept is possible 2 cycles after the first.
- MUL a=0xFFFFFFFF b=3 -> out_valid exactly 33 cycles after accept; Result=0xFFFFFFFD, C=0, V=0. in_ready stays 0 throughout BUSY.
- UDIV a=100 b=7 -> Result=14. UREM a=100 b=7 -> Result=2. UDIV a=9 b=0 -> Result=0xFFFFFFFF, V=1. UREM a=9 b=0 -> Result=9, V=1.
- Backpressure: finish AND a=0xF0F0 b=0xFF00 with out_ready=0 for 5 cycles -> Result=0xF000 held stable and out_valid held; IDLE on the first out_ready=1 edge.
- Mid-op reset: assert reset=0 at BUSY cycle 10 of a MUL -> outputs go to reset values immediately (asynchronously). After release, a new ADD 2+3 gives Result=5. Repeat with WIDTH=8: MUL 0x10*0x10 -> Result=0x00, Z=1, latency 9.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle add/sub/and/or, iterative shift-add multiply
// and restoring unsigned divide/remainder, with valid/ready handshakes on both sides.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_UDIV = 3'b101,
    OP_UREM = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand (MUL) or dividend/quotient shifter (DIV)
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  // Single-cycle datapath
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    sub     = (op_t'(ALUControl) == OP_SUB);
    b_eff   = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_t'(ALUControl))
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      default: alu_res = '0;
    endcase
  end

  // One iteration of the multi-cycle ops
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n, fin_res;
  logic             div_zero;

  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh  = {1'b0, acc_q[WIDTH-1:0], opa_q[WIDTH-1]} >> 0;
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, opb_q};
    // Borrow out of the trial subtraction means the divisor did not fit.
    ge      = ~trial[WIDTH];
    rem_n   = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n   = {opa_q[WIDTH-2:0], ge};
    div_zero = (opb_q == '0);
    case (op_q)
      OP_MUL:  fin_res = mul_acc;
      OP_UDIV: fin_res = quo_n;
      default: fin_res = rem_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op_t'(ALUControl);
          case (op_t'(ALUControl))
            OP_MUL, OP_UDIV, OP_UREM: begin
              opa_d   = a;
              opb_d   = b;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = BUSY;
            end
            default: begin
              res_d   = alu_res;
              flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
              state_d = DONE;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = rem_n;
          opa_d = quo_n;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d   = fin_res;
          flags_d = {fin_res[WIDTH-1], (fin_res == '0), 1'b0,
                     (op_q != OP_MUL) && div_zero};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model (WIDTH 32 and 8).
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] a, b, Result;
  logic [2:0]  ALUControl;
  logic [3:0]  ALUFlags;

  logic        in_valid8, out_ready8;
  logic        in_ready8, out_valid8;
  logic [7:0]  a8, b8, Result8;
  logic [2:0]  ALUControl8;
  logic [3:0]  ALUFlags8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .ALUFlags(ALUFlags)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ALUControl(ALUControl8), .out_valid(out_valid8),
    .out_ready(out_ready8), .Result(Result8), .ALUFlags(ALUFlags8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x, y;
    int          hold;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f);
    longint s;
    logic [63:0] p;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: begin
        p = {32'b0, x} + {32'b0, y};
        r = p[31:0]; c = p[32];
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y; c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd5: if (y == 0) begin r = '1; v = 1'b1; end else r = x / y;
      3'd6: if (y == 0) begin r = x;  v = 1'b1; end else r = x % y;
      default: r = '0;
    endcase
    f = {r[31], (r == 0), c, v};
  endfunction

  // Issue one op on the 32-bit unit, check latency, busy in_ready, result,
  // stability under backpressure and return to IDLE after the handshake.
  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int hold, input logic [31:0] er,
                       input logic [3:0] ef, input int elat);
    int n, lat;
    logic busy_rdy;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check({nm, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; ALUControl = op; a = x; b = y; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; ALUControl = 3'($urandom);
    lat = 1; busy_rdy = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      busy_rdy |= in_ready;
      @(posedge clk); #1; lat++;
    end
    check({nm, ".latency"}, lat, elat);
    check({nm, ".busy_in_ready"}, busy_rdy, 0);
    check({nm, ".Result"}, Result, er);
    check({nm, ".ALUFlags"}, ALUFlags, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, ".held_valid"}, out_valid, 1);
      check({nm, ".held_Result"}, Result, er);
      check({nm, ".held_flags"}, ALUFlags, ef);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, ".post_valid"}, out_valid, 0);
    check({nm, ".post_in_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic do_op8(input string nm, input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef,
                        input int elat);
    int lat;
    in_valid8 = 1'b1; ALUControl8 = op; a8 = x; b8 = y; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check({nm, ".latency"}, lat, elat);
    check({nm, ".Result"}, Result8, er);
    check({nm, ".ALUFlags"}, ALUFlags8, ef);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check({nm, ".post_in_ready"}, in_ready8, 1);
    out_ready8 = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y, er;
    logic [3:0]  ef;

    tbl[0]  = '{3'd0, 32'h7FFFFFFF, 32'h1,     0, 32'h80000000, 4'b1001, 1};
    tbl[1]  = '{3'd1, 32'd5,        32'd5,     0, 32'h0,        4'b0110, 1};
    tbl[2]  = '{3'd4, 32'hFFFFFFFF, 32'd3,     0, 32'hFFFFFFFD, 4'b1000, 33};
    tbl[3]  = '{3'd5, 32'd100,      32'd7,     0, 32'd14,       4'b0000, 33};
    tbl[4]  = '{3'd6, 32'd100,      32'd7,     1, 32'd2,        4'b0000, 33};
    tbl[5]  = '{3'd5, 32'd9,        32'd0,     0, 32'hFFFFFFFF, 4'b1001, 33};
    tbl[6]  = '{3'd6, 32'd9,        32'd0,     0, 32'd9,        4'b0001, 33};
    tbl[7]  = '{3'd2, 32'hF0F0,     32'hFF00,  5, 32'hF000,     4'b0000, 1};
    tbl[8]  = '{3'd7, 32'd5,        32'd6,     0, 32'h0,        4'b0100, 1};
    tbl[9]  = '{3'd1, 32'd0,        32'd1,     0, 32'hFFFFFFFF, 4'b1000, 1};
    tbl[10] = '{3'd1, 32'h80000000, 32'd1,     0, 32'h7FFFFFFF, 4'b0011, 1};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ALUControl = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; ALUControl8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.Result", Result, 0);
    check("reset.ALUFlags", ALUFlags, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].hold,
            tbl[i].r, tbl[i].f, tbl[i].lat);

    // Mid-operation asynchronous reset, then a clean op afterwards.
    in_valid = 1'b1; ALUControl = 3'd4; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst.busy", in_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst.in_ready", in_ready, 1);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.Result", Result, 0);
    check("midrst.ALUFlags", ALUFlags, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_op("after_rst_add", 3'd0, 32'd2, 32'd3, 0, 32'd5, 4'b0000, 1);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      x  = $urandom;
      y  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      model(op, x, y, er, ef);
      do_op($sformatf("rnd%0d_op%0d", i, op), op, x, y, $urandom_range(0, 2), er, ef,
            (op >= 3'd4 && op <= 3'd6) ? 33 : 1);
    end

    do_op8("w8_mul", 3'd4, 8'h10, 8'h10, 8'h00, 4'b0100, 9);
    do_op8("w8_udiv", 3'd5, 8'hC8, 8'h0A, 8'h14, 4'b0000, 9);
    do_op8("w8_add", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);
    in_valid8 = 1'b1; ALUControl8 = 3'd4; a8 = 8'h0F; b8 = 8'h0F;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("w8_midrst.in_ready", in_ready8, 1);
    check("w8_midrst.out_valid", out_valid8, 0);
    check("w8_midrst.Result", Result8, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_op8("w8_after_rst", 3'd0, 8'd2, 8'd3, 8'd5, 4'b0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
